// File: rtl/usb_tx_bit_stuffer_pkg.sv
// Shared USB SIE definitions: bit-stuffing FSM states and the default
// consecutive-ones run length. The RX unstuffer imports the same package.
package usb_tx_bit_stuffer_pkg;

   // Six consecutive ones on the wire force an inserted zero.
   localparam int USB_STUFF_RUN = 6;

   // PASS accepts upstream data; STUFF owns the output slot for one zero.
   typedef enum logic {
      ST_PASS  = 1'b0,
      ST_STUFF = 1'b1
   } usb_stuff_state_e;

endpackage

// File: rtl/usb_tx_bit_stuffer_sat_counter.sv
// Saturating event counter with synchronous clear. Clear wins over a
// coincident increment, so a clear always leaves the counter at zero.
module usb_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] value_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   // Next value: clear has priority, increment stops at all-ones.
   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (inc_i && (value_q != CNT_MAX)) begin
         value_d = value_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// USB transmit bit stuffer. Sits between the packet serializer and the NRZI
// encoder, inserting a zero after STUFF_RUN consecutive ones while stuffEn is
// high. Output is a single registered slot with valid/ready handshake.
module usb_tx_bit_stuffer
   import usb_tx_bit_stuffer_pkg::*;
#(
   parameter int STUFF_RUN = USB_STUFF_RUN,
   parameter int CNT_W     = 8
) (
   input  logic             clk12,
   input  logic             RST_N,
   input  logic             inValid,
   input  logic             inBit,
   input  logic             stuffEn,
   output logic             inReady,
   output logic             outValid,
   output logic             outBit,
   output logic             outIsStuff,
   input  logic             outReady,
   input  logic             cntClear,
   output logic [CNT_W-1:0] stuffCount
);

   localparam int               ONES_W   = $clog2(STUFF_RUN + 1);
   localparam logic [ONES_W-1:0] RUN_LIM = ONES_W'(STUFF_RUN);

   usb_stuff_state_e  state_q, state_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic              out_valid_q, out_valid_d;
   logic              out_bit_q, out_bit_d;
   logic              out_stuff_q, out_stuff_d;

   logic              slot_free;
   logic              accept;
   logic              stuff_load;
   logic [ONES_W-1:0] ones_inc;

   // The output register can take a new bit when empty or being drained now.
   assign slot_free = !out_valid_q || outReady;

   // Upstream is stalled for the whole STUFF state so the zero lands in order.
   assign inReady   = (state_q == ST_PASS) && slot_free;
   assign accept    = inValid && inReady;
   assign ones_inc  = ones_q + ONES_W'(1);

   // Next-state, run counter and output slot update.
   always_comb begin
      state_d     = state_q;
      ones_d      = ones_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_stuff_d = out_stuff_q;
      stuff_load  = 1'b0;

      // A consumed bit empties the slot unless something reloads it below.
      if (slot_free) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_PASS: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_bit_d   = inBit;
               out_stuff_d = 1'b0;
               if (stuffEn && inBit) begin
                  ones_d = ones_inc;
                  if (ones_inc == RUN_LIM) begin
                     state_d = ST_STUFF;
                  end
               end else begin
                  // A zero or a bypassed bit (SYNC/EOP) breaks the run.
                  ones_d = '0;
               end
            end
         end
         ST_STUFF: begin
            // Completes regardless of inValid/stuffEn so a run ending on the
            // final packet bit still gets its zero.
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_bit_d   = 1'b0;
               out_stuff_d = 1'b1;
               ones_d      = '0;
               stuff_load  = 1'b1;
               state_d     = ST_PASS;
            end
         end
         default: begin
            state_d = ST_PASS;
            ones_d  = '0;
         end
      endcase
   end

   // FSM, run counter and output slot registers.
   always_ff @(posedge clk12 or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_PASS;
         ones_q      <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_stuff_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ones_q      <= ones_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_stuff_q <= out_stuff_d;
      end
   end

   assign outValid   = out_valid_q;
   assign outBit     = out_bit_q;
   assign outIsStuff = out_stuff_q;

   usb_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stuff_cnt (
      .clk_i   (clk12),
      .rst_ni  (RST_N),
      .inc_i   (stuff_load),
      .clr_i   (cntClear),
      .value_o (stuffCount)
   );

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Directed bench for usb_tx_bit_stuffer (STUFF_RUN=6, CNT_W=2).
module tb_usb_tx_bit_stuffer;

   logic       clk12 = 1'b0;
   logic       RST_N = 1'b0;
   logic       inValid = 1'b0;
   logic       inBit = 1'b0;
   logic       stuffEn = 1'b0;
   logic       outReady = 1'b1;
   logic       cntClear = 1'b0;
   logic       inReady;
   logic       outValid;
   logic       outBit;
   logic       outIsStuff;
   logic [1:0] stuffCount;

   int n_checks = 0;
   int n_errors = 0;

   logic stim_b [64];
   logic stim_e [64];
   int   stim_n;
   int   gap_mode;
   int   rdy_mode;

   logic [63:0] obs_bits, obs_stuff;
   int          obs_n;
   logic [63:0] exp_bits, exp_stuff;
   int          exp_n;
   int          inrdy_low;
   int          hold_bad;

   always #5 clk12 = ~clk12;

   usb_tx_bit_stuffer #(
      .STUFF_RUN (6),
      .CNT_W     (2)
   ) dut (
      .clk12      (clk12),
      .RST_N      (RST_N),
      .inValid    (inValid),
      .inBit      (inBit),
      .stuffEn    (stuffEn),
      .inReady    (inReady),
      .outValid   (outValid),
      .outBit     (outBit),
      .outIsStuff (outIsStuff),
      .outReady   (outReady),
      .cntClear   (cntClear),
      .stuffCount (stuffCount)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic b, input logic e, input logic r, input logic c);
      @(negedge clk12);
      inValid  = v;
      inBit    = b;
      stuffEn  = e;
      outReady = r;
      cntClear = c;
      #1;
   endtask

   task automatic rst_assert();
      @(negedge clk12);
      RST_N    = 1'b0;
      inValid  = 1'b0;
      inBit    = 1'b0;
      stuffEn  = 1'b0;
      outReady = 1'b1;
      cntClear = 1'b0;
      #1;
   endtask

   task automatic rst_release();
      repeat (2) @(negedge clk12);
      RST_N = 1'b1;
      #1;
   endtask

   task automatic set_stim(input logic [63:0] bits, input int n, input logic en);
      for (int i = 0; i < n; i++) begin
         stim_b[i] = bits[n-1-i];
         stim_e[i] = en;
      end
      stim_n = n;
   endtask

   // Reference: whole-stream stuffing of the stimulus arrays.
   task automatic ref_stuff();
      int run;
      run       = 0;
      exp_bits  = '0;
      exp_stuff = '0;
      exp_n     = 0;
      for (int i = 0; i < stim_n; i++) begin
         exp_bits  = {exp_bits[62:0], stim_b[i]};
         exp_stuff = {exp_stuff[62:0], 1'b0};
         exp_n++;
         if (stim_e[i] && stim_b[i]) run++;
         else run = 0;
         if (run == 6) begin
            exp_bits  = {exp_bits[62:0], 1'b0};
            exp_stuff = {exp_stuff[62:0], 1'b1};
            exp_n++;
            run = 0;
         end
      end
   endtask

   // Feeds stim arrays, records every consumed output bit, checks hold under stall.
   task automatic run_stream(input int max_cycles);
      int   idx, cyc, idle;
      logic prev_hold, prev_bit, prev_stuff;
      idx = 0; cyc = 0; idle = 0;
      prev_hold = 1'b0; prev_bit = 1'b0; prev_stuff = 1'b0;
      obs_bits = '0; obs_stuff = '0; obs_n = 0;
      inrdy_low = 0; hold_bad = 0;
      while ((idx < stim_n || idle < 3) && cyc < max_cycles) begin
         @(negedge clk12);
         if (prev_hold && !(outValid && outBit == prev_bit && outIsStuff == prev_stuff))
            hold_bad++;
         outReady = (rdy_mode != 0) ? ((cyc % 2) == 0) : 1'b1;
         inValid  = (idx < stim_n) && ((gap_mode == 0) || ((cyc % 3) != 1));
         inBit    = (idx < stim_n) ? stim_b[idx] : 1'b0;
         stuffEn  = (idx < stim_n) ? stim_e[idx] : 1'b0;
         cntClear = 1'b0;
         #1;
         if (!inReady) inrdy_low++;
         if (outValid && outReady) begin
            obs_bits  = {obs_bits[62:0], outBit};
            obs_stuff = {obs_stuff[62:0], outIsStuff};
            obs_n++;
         end
         prev_hold  = outValid && !outReady;
         prev_bit   = outBit;
         prev_stuff = outIsStuff;
         if (inValid && inReady) idx++;
         if (idx >= stim_n && !outValid) idle++;
         else idle = 0;
         cyc++;
      end
      chk("run_done", (idx == stim_n && idle >= 3), 1);
      inValid  = 1'b0;
      stuffEn  = 1'b0;
      outReady = 1'b1;
   endtask

   initial begin
      gap_mode = 0;
      rdy_mode = 0;

      // Reset values while held low, then inReady right after release.
      rst_assert();
      chk("rst_outValid", outValid, 0);
      chk("rst_outBit", outBit, 0);
      chk("rst_outIsStuff", outIsStuff, 0);
      chk("rst_stuffCount", stuffCount, 0);
      rst_release();
      chk("rel_inReady", inReady, 1);

      // One-cycle latency and hold under backpressure.
      step(1, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("lat_outValid", outValid, 1);
      chk("lat_outBit", outBit, 1);
      chk("lat_outIsStuff", outIsStuff, 0);
      chk("stall_inReady", inReady, 0);
      step(0, 0, 1, 0, 0);
      chk("hold_outValid", outValid, 1);
      chk("hold_outBit", outBit, 1);

      // 1111110 -> 11111100
      rst_assert(); rst_release();
      set_stim(64'b1111110, 7, 1'b1);
      run_stream(200);
      chk("t1_len", obs_n, 8);
      chk("t1_bits", obs_bits, 64'b11111100);
      chk("t1_stuff", obs_stuff, 64'b00000010);
      chk("t1_cnt", stuffCount, 1);

      // Twelve ones -> two stuffed zeros, inReady low one cycle each.
      rst_assert(); rst_release();
      set_stim(64'hFFF, 12, 1'b1);
      run_stream(200);
      chk("t2_len", obs_n, 14);
      chk("t2_bits", obs_bits, 64'b11111101111110);
      chk("t2_stuff", obs_stuff, 64'b00000010000001);
      chk("t2_inrdy_low", inrdy_low, 2);
      chk("t2_cnt", stuffCount, 2);

      // Bypass: eight ones pass untouched, then a fresh run starts at 1.
      rst_assert(); rst_release();
      set_stim(64'hFF, 8, 1'b0);
      run_stream(200);
      chk("t3a_len", obs_n, 8);
      chk("t3a_bits", obs_bits, 64'hFF);
      chk("t3a_stuff", obs_stuff, 0);
      chk("t3a_cnt", stuffCount, 0);
      set_stim(64'b111111, 6, 1'b1);
      run_stream(200);
      chk("t3b_len", obs_n, 7);
      chk("t3b_bits", obs_bits, 64'b1111110);
      chk("t3b_stuff", obs_stuff, 64'b0000001);
      chk("t3b_cnt", stuffCount, 1);

      // Backpressure 1010... with input gaps against the reference.
      rst_assert(); rst_release();
      gap_mode = 1;
      rdy_mode = 1;
      set_stim(64'b111111110111111011111111, 24, 1'b1);
      ref_stuff();
      run_stream(400);
      chk("t4_len_hand", obs_n, 27);
      chk("t4_len", obs_n, exp_n);
      chk("t4_bits", obs_bits, exp_bits);
      chk("t4_stuff", obs_stuff, exp_stuff);
      chk("t4_hold", hold_bad, 0);
      chk("t4_cnt", stuffCount, 3);
      gap_mode = 0;
      rdy_mode = 0;

      // Reset while in STUFF discards the pending zero.
      rst_assert(); rst_release();
      repeat (6) step(1, 1, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("t5_in_stuff_inReady", inReady, 0);
      RST_N = 1'b0;
      #1;
      chk("t5_async_outValid", outValid, 0);
      chk("t5_async_outIsStuff", outIsStuff, 0);
      rst_release();
      chk("t5_rel_inReady", inReady, 1);
      set_stim(64'b111111, 6, 1'b1);
      run_stream(200);
      chk("t5_len", obs_n, 7);
      chk("t5_bits", obs_bits, 64'b1111110);
      chk("t5_stuff", obs_stuff, 64'b0000001);
      chk("t5_cnt", stuffCount, 1);

      // Counter saturation and clear (including clear coincident with increment).
      rst_assert(); rst_release();
      set_stim(64'h3FFFFFFF, 30, 1'b1);
      run_stream(300);
      chk("t6_len", obs_n, 35);
      chk("t6_sat", stuffCount, 3);
      repeat (6) step(1, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("t6_pre_clr", stuffCount, 3);
      step(0, 0, 0, 1, 0);
      chk("t6_clr_inc_cnt", stuffCount, 0);
      chk("t6_clr_inc_stuffbit", outIsStuff, 1);
      step(0, 0, 0, 1, 0);
      chk("t6_drained", outValid, 0);
      set_stim(64'b111111, 6, 1'b1);
      run_stream(200);
      chk("t6_cnt_one", stuffCount, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      chk("t6_clr", stuffCount, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
